// File: rtl/ff_capture_if.sv
// ff_capture_if: pin, format control and word handshake bundle for ff_capture
interface ff_capture_if #(parameter int WIDTH = 8);
  logic             clk_enable;
  logic             din;
  logic [1:0]       ff;
  logic             clr;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      err_count;
  logic             overflow;
  modport master(output clk_enable, din, ff, clr, out_ready,
                 input out_data, out_valid, err_count, overflow);
  modport slave(input clk_enable, din, ff, clr, out_ready,
                output out_data, out_valid, err_count, overflow);
endinterface

// File: rtl/ff_capture.sv
// ff_capture: dual-edge pin receiver that checks forced levels or deserialises SDR/DDR words
module ff_capture #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  ff_capture_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [1:0]       rst_sync_q;
  logic [1:0]       ff_q, ff_d;
  logic             neg_s_q;
  logic [WIDTH-1:0] sr_q, sr_d, data_q, data_d, sr_shift;
  logic [WIDTH:0]   sdr_w;
  logic [WIDTH+1:0] ddr_w;
  logic [CW-1:0]    cnt_q, cnt_d, step;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic [15:0]      err_q, err_d;
  logic             run, done, word;
  assign run           = bus.clk_enable & rst_sync_q[1];
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.err_count = err_q;
  assign bus.overflow  = ovf_q;
  // reset asserts at once, releases two rising edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  // falling-edge pin sample, the first bit of each DDR pair
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) neg_s_q <= 1'b0;
    else neg_s_q <= bus.din;
  // next state: format tracking, level check, deserialiser and handshake
  always_comb begin
    state_d  = state_q;
    ff_d     = ff_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    word     = 1'b0;
    sdr_w    = {sr_q, bus.din};
    ddr_w    = {sr_q, neg_s_q, bus.din};
    step     = ff_q[0] ? CW'(2) : CW'(1);
    sr_shift = ff_q[0] ? ddr_w[WIDTH-1:0] : sdr_w[WIDTH-1:0];
    done     = (cnt_q + step) == CW'(WIDTH);
    if (run) begin
      if (bus.clr) begin
        err_d = 16'h0;
        ovf_d = 1'b0;
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        if (state_q == IDLE || state_q == FLUSH) begin
          ff_d    = bus.ff;
          state_d = bus.ff[1] ? SHIFT : CHECK;
        end else if (bus.ff != ff_q) begin
          state_d = FLUSH;
          sr_d    = '0;
          cnt_d   = '0;
        end else if (state_q == CHECK) begin
          err_d = (bus.din != ff_q[0] && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        end else begin
          sr_d  = sr_shift;
          cnt_d = done ? '0 : cnt_q + step;
          word  = done;
        end
        if (word && (!valid_q || bus.out_ready)) begin
          data_d  = sr_shift;
          valid_d = 1'b1;
        end else if (word) ovf_d = 1'b1;
        else if (bus.out_ready) valid_d = 1'b0;
      end
    end
  end
  // state registers, all cleared while reset is held or not yet released
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ff_q    <= 2'b00;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      ff_q    <= ff_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
endmodule
